// File: rtl/dbi_pkg.sv
// Shared DBI definitions: FSM state encoding, idle pin levels, default bus width.
// Latency: none (declarations only).
// Backpressure: not applicable.
package dbi_pkg;

  localparam int DBI_IF_D_W_DEF = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CMD_LO    = 3'd1,
    CMD_HI    = 3'd2,
    DAT_LO    = 3'd3,
    DAT_HI    = 3'd4,
    WAIT_BEAT = 3'd5,
    HRST      = 3'd6
  } dbi_state_e;

  // Pin levels while no transaction or reset is in progress
  localparam logic CSX_IDLE  = 1'b1;
  localparam logic DCX_IDLE  = 1'b1;
  localparam logic WRX_IDLE  = 1'b1;
  localparam logic RDX_IDLE  = 1'b1;
  localparam logic RESX_IDLE = 1'b1;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/dbi_tx_phy_if.sv
// Beat handshake from the upstream formatter plus the DBI type-C pin bundle.
// Latency: none (wiring only).
// Backpressure: upstream holds a beat while dtp_tx_rdy_o is low.
interface dbi_tx_phy_if
  import dbi_pkg::*;
#(
  parameter int DBI_IF_D_W = DBI_IF_D_W_DEF
);
  logic                  dtp_dbi_hrst_i;
  logic [DBI_IF_D_W-1:0] dtp_tx_cmd_typ_i;
  logic [DBI_IF_D_W-1:0] dtp_tx_cmd_dat_i;
  logic                  dtp_tx_last_i;
  logic                  dtp_tx_no_dat_i;
  logic                  dtp_tx_vld_i;
  logic                  dtp_tx_rdy_o;
  logic                  dbi_csx_o;
  logic                  dbi_dcx_o;
  logic                  dbi_wrx_o;
  logic                  dbi_rdx_o;
  logic                  dbi_resx_o;
  logic [DBI_IF_D_W-1:0] dbi_d_o;

  // Upstream beat producer / pin observer
  modport master (
    output dtp_dbi_hrst_i, dtp_tx_cmd_typ_i, dtp_tx_cmd_dat_i,
    output dtp_tx_last_i, dtp_tx_no_dat_i, dtp_tx_vld_i,
    input  dtp_tx_rdy_o,
    input  dbi_csx_o, dbi_dcx_o, dbi_wrx_o, dbi_rdx_o, dbi_resx_o, dbi_d_o
  );

  // PHY side
  modport slave (
    input  dtp_dbi_hrst_i, dtp_tx_cmd_typ_i, dtp_tx_cmd_dat_i,
    input  dtp_tx_last_i, dtp_tx_no_dat_i, dtp_tx_vld_i,
    output dtp_tx_rdy_o,
    output dbi_csx_o, dbi_dcx_o, dbi_wrx_o, dbi_rdx_o, dbi_resx_o, dbi_d_o
  );
endinterface

// File: rtl/dbi_phase_timer.sv
// Down-counter timing one WRX/RESX phase; done is high in the last cycle of the phase.
// Latency: a load of N gives done in the N-th cycle after the loading edge.
// Backpressure: none; counter parks at zero and never wraps.
module dbi_phase_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_done
);
  logic [CNT_W-1:0] r_cnt;

  // Load on phase entry, count down, saturate at zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = (r_cnt == CNT_W'(1));
endmodule

// File: rtl/dbi_tx_phy.sv
// DBI type-C write PHY: turns command/data beats into CSX/DCX/WRX/D pin sequences and RESX pulses.
// Latency: pins are registered; WRX falls in the cycle after a beat is accepted.
// Backpressure: rdy only in IDLE/WAIT_BEAT; optional byte counter enabled by DBI_PHY_STAT_EN.
module dbi_tx_phy
  import dbi_pkg::*;
#(
  parameter int DBI_IF_D_W  = DBI_IF_D_W_DEF,
  parameter int WR_LOW_CYC  = 2,
  parameter int WR_HIGH_CYC = 2,
  parameter int HRST_CYC    = 1250
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef DBI_PHY_STAT_EN
  output logic [31:0] stat_byte_cnt_o,
`endif
  dbi_tx_phy_if.slave bus
);
  localparam int CNT_W = $clog2(max3(WR_LOW_CYC, WR_HIGH_CYC, HRST_CYC) + 1);

  dbi_state_e            r_state;
  logic                  r_rdy;
  logic                  r_csx;
  logic                  r_dcx;
  logic                  r_wrx;
  logic                  r_resx;
  logic [DBI_IF_D_W-1:0] r_d;
  logic [DBI_IF_D_W-1:0] r_dat;
  logic                  r_last;
  logic                  r_no_dat;
  logic                  w_accept;
  logic                  w_done;
  logic                  w_tmr_load;
  logic [CNT_W-1:0]      w_tmr_val;

  assign w_accept = bus.dtp_tx_vld_i & r_rdy;

  // Timer reload whenever the FSM enters a timed phase
  always_comb begin
    w_tmr_load = 1'b0;
    w_tmr_val  = '0;
    case (r_state)
      IDLE, WAIT_BEAT: begin
        if (w_accept) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = bus.dtp_dbi_hrst_i ? CNT_W'(HRST_CYC) : CNT_W'(WR_LOW_CYC);
        end
      end
      CMD_LO, DAT_LO: begin
        if (w_done) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = CNT_W'(WR_HIGH_CYC);
        end
      end
      CMD_HI: begin
        if (w_done && !r_no_dat) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = CNT_W'(WR_LOW_CYC);
        end
      end
      default: ;
    endcase
  end

  dbi_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_done     (w_done)
  );

`ifdef DBI_PHY_STAT_EN
  logic [31:0] r_stat;
  // Count every WRX rising edge (end of each low phase); wraps naturally
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stat <= '0;
    end else if (w_done && (r_state == CMD_LO || r_state == DAT_LO)) begin
      r_stat <= r_stat + 32'd1;
    end
  end
  assign stat_byte_cnt_o = r_stat;
`endif

  // Transaction FSM; pins are set on the edge that enters each state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_rdy    <= 1'b0;
      r_csx    <= CSX_IDLE;
      r_dcx    <= DCX_IDLE;
      r_wrx    <= WRX_IDLE;
      r_resx   <= RESX_IDLE;
      r_d      <= '0;
      r_dat    <= '0;
      r_last   <= 1'b0;
      r_no_dat <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_rdy <= 1'b1;
          if (w_accept) begin
            r_rdy    <= 1'b0;
            r_dat    <= bus.dtp_tx_cmd_dat_i;
            r_last   <= bus.dtp_tx_last_i;
            r_no_dat <= bus.dtp_tx_no_dat_i;
            if (bus.dtp_dbi_hrst_i) begin
              r_state <= HRST;
              r_resx  <= 1'b0;
            end else begin
              r_state <= CMD_LO;
              r_csx   <= 1'b0;
              r_dcx   <= 1'b0;
              r_d     <= bus.dtp_tx_cmd_typ_i;
              r_wrx   <= 1'b0;
            end
          end
        end
        CMD_LO, DAT_LO: begin
          if (w_done) begin
            r_state <= (r_state == CMD_LO) ? CMD_HI : DAT_HI;
            r_wrx   <= 1'b1;
          end
        end
        CMD_HI: begin
          if (w_done) begin
            if (r_no_dat) begin
              // Command-only transaction always closes here
              r_state <= IDLE;
              r_rdy   <= 1'b1;
              r_csx   <= CSX_IDLE;
              r_dcx   <= DCX_IDLE;
              r_d     <= '0;
            end else begin
              r_state <= DAT_LO;
              r_dcx   <= 1'b1;
              r_d     <= r_dat;
              r_wrx   <= 1'b0;
            end
          end
        end
        DAT_HI: begin
          if (w_done) begin
            r_rdy <= 1'b1;
            if (r_last) begin
              r_state <= IDLE;
              r_csx   <= CSX_IDLE;
              r_dcx   <= DCX_IDLE;
              r_d     <= '0;
            end else begin
              // Keep CSX low, DCX/D held, until the next data beat
              r_state <= WAIT_BEAT;
            end
          end
        end
        WAIT_BEAT: begin
          if (w_accept) begin
            r_rdy  <= 1'b0;
            r_last <= bus.dtp_tx_last_i;
            if (bus.dtp_dbi_hrst_i) begin
              r_state <= HRST;
              r_csx   <= CSX_IDLE;
              r_dcx   <= DCX_IDLE;
              r_d     <= '0;
              r_resx  <= 1'b0;
            end else begin
              r_state <= DAT_LO;
              r_d     <= bus.dtp_tx_cmd_dat_i;
              r_wrx   <= 1'b0;
            end
          end
        end
        HRST: begin
          if (w_done) begin
            r_state <= IDLE;
            r_rdy   <= 1'b1;
            r_resx  <= RESX_IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_rdy   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dtp_tx_rdy_o = r_rdy;
  assign bus.dbi_csx_o    = r_csx;
  assign bus.dbi_dcx_o    = r_dcx;
  assign bus.dbi_wrx_o    = r_wrx;
  assign bus.dbi_rdx_o    = RDX_IDLE;
  assign bus.dbi_resx_o   = r_resx;
  assign bus.dbi_d_o      = r_d;
endmodule

// File: tb/tb_dbi_tx_phy.sv
// Randomised and directed bench for dbi_tx_phy with a transaction-level scoreboard.
// Latency: not applicable.
// Backpressure: driver waits on rdy with a bounded cycle budget.
module tb_dbi_tx_phy;
  localparam int DW = 8;
  localparam int LO = 2;
  localparam int HI = 2;
  localparam int HR = 10;

  typedef struct {
    bit       hrst;
    bit       dcx;
    bit [7:0] d;
  } exp_t;

  logic  clk;
  logic  rst_n;
  exp_t  q[$];
  int    n_tests;
  int    n_fail;
  int    rises;
  bit    in_txn;
  logic [31:0] stat;

  dbi_tx_phy_if #(.DBI_IF_D_W(DW)) bus ();

  dbi_tx_phy #(
    .DBI_IF_D_W  (DW),
    .WR_LOW_CYC  (LO),
    .WR_HIGH_CYC (HI),
    .HRST_CYC    (HR)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
`ifdef DBI_PHY_STAT_EN
    .stat_byte_cnt_o (stat),
`endif
    .bus             (bus.slave)
  );

`ifndef DBI_PHY_STAT_EN
  assign stat = 32'd0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level expectation: which bus writes / resets one beat produces
  task automatic model_push(input bit h, input bit [7:0] c, input bit [7:0] dt,
                            input bit l, input bit nd);
    if (h) begin
      q.push_back('{hrst: 1'b1, dcx: 1'b0, d: 8'h00});
      in_txn = 1'b0;
    end else if (!in_txn) begin
      q.push_back('{hrst: 1'b0, dcx: 1'b0, d: c});
      if (nd) begin
        in_txn = 1'b0;
      end else begin
        q.push_back('{hrst: 1'b0, dcx: 1'b1, d: dt});
        in_txn = !l;
      end
    end else begin
      q.push_back('{hrst: 1'b0, dcx: 1'b1, d: dt});
      in_txn = !l;
    end
  endtask

  task automatic send(input bit h, input bit [7:0] c, input bit [7:0] dt,
                      input bit l, input bit nd);
    bit got;
    got = 1'b0;
    @(negedge clk);
    bus.dtp_dbi_hrst_i   = h;
    bus.dtp_tx_cmd_typ_i = c;
    bus.dtp_tx_cmd_dat_i = dt;
    bus.dtp_tx_last_i    = l;
    bus.dtp_tx_no_dat_i  = nd;
    bus.dtp_tx_vld_i     = 1'b1;
    for (int i = 0; i < 500 && !got; i++) begin
      if (i > 0) @(negedge clk);
      if (bus.dtp_tx_rdy_o === 1'b1) begin
        @(posedge clk);
        got = 1'b1;
      end
    end
    #1;
    bus.dtp_tx_vld_i = 1'b0;
    chk("beat_accepted", {31'd0, got}, 32'd1);
    if (got) model_push(h, c, dt, l, nd);
  endtask

  // Count consecutive low cycles of a pin starting now; stops at the first high after a low
  task automatic low_run(input int sel, output int n);
    logic v;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      v = (sel == 0) ? bus.dbi_csx_o : bus.dbi_resx_o;
      if (v === 1'b0) n++;
      else if (n > 0) break;
    end
  endtask

  // Monitor: pops the scoreboard on every WRX rise and every end of RESX pulse
  initial begin : monitor
    logic pw, pr;
    int   low_n, hr_n;
    bit   quiet;
    exp_t e;
    pw = 1'b1; pr = 1'b1; low_n = 0; hr_n = 0; quiet = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        pw = 1'b1; pr = 1'b1; low_n = 0; hr_n = 0; quiet = 1'b1; rises = 0;
      end else begin
        if (bus.dbi_wrx_o === 1'b0) begin
          low_n++;
        end else begin
          if (pw === 1'b0) begin
            rises++;
            chk("wrx_low_width", low_n, LO);
            chk("csx_at_wrx_rise", {31'd0, bus.dbi_csx_o}, 32'd0);
            chk("write_expected", {31'd0, (q.size() > 0)}, 32'd1);
            if (q.size() > 0) begin
              e = q.pop_front();
              chk("write_is_hrst", {31'd0, e.hrst}, 32'd0);
              chk("write_dcx", {31'd0, bus.dbi_dcx_o}, {31'd0, e.dcx});
              chk("write_d", {24'd0, bus.dbi_d_o}, {24'd0, e.d});
            end
          end
          low_n = 0;
        end
        if (bus.dbi_resx_o === 1'b0) begin
          hr_n++;
          if (bus.dbi_wrx_o !== 1'b1 || bus.dbi_csx_o !== 1'b1 || bus.dtp_tx_rdy_o !== 1'b0)
            quiet = 1'b0;
        end else if (pr === 1'b0) begin
          chk("hrst_len", hr_n, HR);
          chk("hrst_quiet", {31'd0, quiet}, 32'd1);
          chk("hrst_expected", {31'd0, (q.size() > 0)}, 32'd1);
          if (q.size() > 0) begin
            e = q.pop_front();
            chk("hrst_is_hrst", {31'd0, e.hrst}, 32'd1);
          end
          hr_n = 0;
          quiet = 1'b1;
        end
        if (in_txn) chk("csx_held_in_txn", {31'd0, bus.dbi_csx_o}, 32'd0);
        pw = bus.dbi_wrx_o;
        pr = bus.dbi_resx_o;
      end
    end
  end

  task automatic check_idle_pins(input string tag);
    chk({tag, "_rdy"},  {31'd0, bus.dtp_tx_rdy_o}, 32'd0);
    chk({tag, "_csx"},  {31'd0, bus.dbi_csx_o},    32'd1);
    chk({tag, "_dcx"},  {31'd0, bus.dbi_dcx_o},    32'd1);
    chk({tag, "_wrx"},  {31'd0, bus.dbi_wrx_o},    32'd1);
    chk({tag, "_rdx"},  {31'd0, bus.dbi_rdx_o},    32'd1);
    chk({tag, "_resx"}, {31'd0, bus.dbi_resx_o},   32'd1);
    chk({tag, "_d"},    {24'd0, bus.dbi_d_o},      32'd0);
`ifdef DBI_PHY_STAT_EN
    chk({tag, "_stat"}, stat, 32'd0);
`endif
  endtask

  initial begin : stim
    int  n;
    bit  found;
    n_tests = 0; n_fail = 0; in_txn = 1'b0;
    rst_n = 1'b0;
    bus.dtp_dbi_hrst_i = 1'b0; bus.dtp_tx_cmd_typ_i = '0; bus.dtp_tx_cmd_dat_i = '0;
    bus.dtp_tx_last_i = 1'b0; bus.dtp_tx_no_dat_i = 1'b0; bus.dtp_tx_vld_i = 1'b0;

    repeat (3) @(negedge clk);
    check_idle_pins("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("rdy_after_release", {31'd0, bus.dtp_tx_rdy_o}, 32'd1);

    // Single command + data byte
    send(1'b0, 8'h2A, 8'h11, 1'b1, 1'b0);
    low_run(0, n);
    chk("cmd_dat_csx_low", n, 2 * (LO + HI));
    chk("cmd_dat_rdy_after", {31'd0, bus.dtp_tx_rdy_o}, 32'd1);

    // Command-only, last ignored
    send(1'b0, 8'h29, 8'h55, 1'b0, 1'b1);
    low_run(0, n);
    chk("no_dat_csx_low", n, LO + HI);
    chk("no_dat_rdy_after", {31'd0, bus.dtp_tx_rdy_o}, 32'd1);

    // Multi-beat burst through WAIT_BEAT
    send(1'b0, 8'h2C, 8'hAA, 1'b0, 1'b0);
    send(1'b0, 8'h99, 8'hBB, 1'b0, 1'b0);
    send(1'b0, 8'h98, 8'hCC, 1'b1, 1'b0);

    // Hardware reset from IDLE
    send(1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
    low_run(1, n);
    chk("hrst_resx_low", n, HR);

    // Hardware reset arriving in WAIT_BEAT
    send(1'b0, 8'h3C, 8'h01, 1'b0, 1'b0);
    send(1'b1, 8'h00, 8'h00, 1'b1, 1'b1);
    low_run(1, n);
    chk("hrst_wait_resx_low", n, HR);

    // Reset during DAT_LO
    send(1'b0, 8'h5A, 8'h77, 1'b1, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (bus.dbi_dcx_o === 1'b1 && bus.dbi_wrx_o === 1'b0 && bus.dbi_csx_o === 1'b0) found = 1'b1;
    end
    chk("reached_dat_lo", {31'd0, found}, 32'd1);
    rst_n = 1'b0;
    q.delete();
    in_txn = 1'b0;
    @(negedge clk);
    check_idle_pins("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    send(1'b0, 8'h2B, 8'h42, 1'b1, 1'b0);

    // Randomised traffic
    for (int k = 0; k < 80; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(($urandom_range(0, 19) == 0), 8'($urandom), 8'($urandom),
           1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    end
    // Close any open burst
    if (in_txn) send(1'b0, 8'h00, 8'hEE, 1'b1, 1'b0);

    for (int i = 0; i < 300 && q.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    chk("end_csx_idle", {31'd0, bus.dbi_csx_o}, 32'd1);
`ifdef DBI_PHY_STAT_EN
    chk("stat_count", stat, rises);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/dbi_tx_phy.md
DBI_TX_PHY -- requirements
Module: dbi_tx_phy

Interface
REQ-001 The module SHALL have parameter DBI_IF_D_W, default 8, giving the DBI data bus and command/data byte width.
REQ-002 The module SHALL have parameter WR_LOW_CYC, default 2, giving the number of clk cycles WRX is held low per bus write (minimum 1).
REQ-003 The module SHALL have parameter WR_HIGH_CYC, default 2, giving the number of clk cycles WRX is held high after each low phase (minimum 1).
REQ-004 The module SHALL have parameter HRST_CYC, default 1250, giving the number of clk cycles RESX is held low per hardware reset.
REQ-005 The module SHALL have one clock and a synchronous active-low reset: clk input 1 (all state on rising edge); rst_n input 1 (synchronous, active-low).
REQ-006 The module SHALL have these ports, one per line (name, direction, width, meaning):
- dtp_dbi_hrst_i  in  1  beat is a panel hardware reset
- dtp_tx_cmd_typ_i  in  DBI_IF_D_W  command byte
- dtp_tx_cmd_dat_i  in  DBI_IF_D_W  data byte
- dtp_tx_last_i  in  1  last beat of transaction
- dtp_tx_no_dat_i  in  1  command-only transaction
- dtp_tx_vld_i  in  1  beat valid
- dtp_tx_rdy_o  out  1  beat accepted when vld&rdy
- dbi_csx_o  out  1  chip select, active low
- dbi_dcx_o  out  1  0 = command byte, 1 = data byte
- dbi_wrx_o  out  1  write strobe; panel samples on rising edge
- dbi_rdx_o  out  1  read strobe, constant 1
- dbi_resx_o  out  1  panel reset, active low
- dbi_d_o  out  DBI_IF_D_W  bus data

Function
REQ-007 The FSM SHALL have states IDLE, CMD_LO, CMD_HI, DAT_LO, DAT_HI, WAIT_BEAT and HRST.
REQ-008 dtp_tx_rdy_o SHALL be 1 only in IDLE and WAIT_BEAT; a beat is captured into a holding register on vld&rdy.
REQ-009 IDLE, non-hrst beat accepted: go to CMD_LO; if hrst beat: go to HRST.
REQ-010 CMD_LO/CMD_HI SHALL drive csx=0, dcx=0, d=cmd_typ; wrx=0 for WR_LOW_CYC cycles, then wrx=1 for WR_HIGH_CYC cycles.
REQ-011 After CMD_HI, a beat with no_dat=0 SHALL go to DAT_LO; with no_dat=1 it SHALL go to IDLE and be treated as last regardless of last.
REQ-012 DAT_LO/DAT_HI SHALL drive csx=0, dcx=1, d=cmd_dat with the same WRX timing as REQ-010.
REQ-013 After DAT_HI: last=1 goes to IDLE (csx=1); last=0 goes to WAIT_BEAT (csx=0, wrx=1, d and dcx held).
REQ-014 WAIT_BEAT, non-hrst beat accepted: go directly to DAT_LO; cmd_typ is ignored (no command re-sent).
REQ-015 A hrst beat accepted in WAIT_BEAT SHALL raise csx in the next cycle and enter HRST.
REQ-016 HRST SHALL drive resx=0 and csx=1 for exactly HRST_CYC cycles, then return to IDLE; last and no_dat are ignored.
REQ-017 csx SHALL be high for at least one cycle between transactions (IDLE lasts at least one cycle).
REQ-018 The phase counter SHALL be $clog2(max(WR_LOW_CYC,WR_HIGH_CYC,HRST_CYC)+1) bits, loaded on state entry, with no wrap-around.
REQ-019 Pin outputs SHALL be registered; acceptance-to-first-WRX-fall latency is 1 cycle.

Reset
REQ-020 While rst_n=0 at a clk edge: state=IDLE, dtp_tx_rdy_o=0, csx=1, dcx=1, wrx=1, rdx=1, resx=1, d=0; dtp_tx_rdy_o=1 in the first cycle after release.
REQ-021 Reset mid-transaction SHALL discard the captured beat and return all pins to idle values in the next cycle, with no partial WRX pulse extended.

Configuration
REQ-022 With DBI_PHY_STAT_EN defined, the module SHALL add output stat_byte_cnt_o (32 bits), incremented on every WRX rising edge, cleared by reset, wrapping 0xFFFFFFFF->0.
REQ-023 Without DBI_PHY_STAT_EN, the port and counter SHALL be absent and behaviour otherwise identical.

Structure
REQ-024 The state encoding and idle pin constants SHALL live in a shared package dbi_pkg, together with the DBI_IF_D_W default.
REQ-025 WRX/RESX phase timing SHALL be a sub-module dbi_phase_timer (load value, done pulse).

Verification
REQ-026 WR_LOW/HIGH=2; beat cmd=0x2A, dat=0x11, last=1 -> csx low 8 cycles, dcx 0 then 1, d 0x2A then 0x11, two WRX rises, csx=1 after.
REQ-027 no_dat=1, cmd=0x29, last=0 -> one WRX pulse with dcx=0, return to IDLE, rdy=1.
REQ-028 Three beats (0x2C; 0xAA, 0xBB, 0xCC; last on 3rd) -> one command write then 3 data writes, csx held low throughout WAIT_BEAT gaps.
REQ-029 hrst beat, HRST_CYC=10 -> resx low exactly 10 cycles, csx=1, no WRX activity, rdy=0 for the duration.
REQ-030 rst_n low during DAT_LO -> next cycle wrx=1, csx=1, rdy=0; after release a new beat transmits normally; with DBI_PHY_STAT_EN, stat_byte_cnt_o=0 after reset.
